// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting path.
// - FSM state type for time_setter.
// - Digit positions inside the {hh,mm,ss} BCD buffer (seconds units = 0 .. hour tens = 5).
// - Per-digit maximum values and button slot indices.
// - digit_max(): legal upper bound of a digit, given the current hour tens.
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEdit,
    StCommit
  } ts_state_e;

  // Digit positions (cursor values)
  localparam logic [2:0] SEC_U = 3'd0;
  localparam logic [2:0] SEC_T = 3'd1;
  localparam logic [2:0] MIN_U = 3'd2;
  localparam logic [2:0] MIN_T = 3'd3;
  localparam logic [2:0] HR_U  = 3'd4;
  localparam logic [2:0] HR_T  = 3'd5;

  // Digit maxima
  localparam logic [3:0] MAX_SEC_U    = 4'd9;
  localparam logic [3:0] MAX_SEC_T    = 4'd5;
  localparam logic [3:0] MAX_MIN_U    = 4'd9;
  localparam logic [3:0] MAX_MIN_T    = 4'd5;
  localparam logic [3:0] MAX_HR_U     = 4'd9;
  localparam logic [3:0] MAX_HR_U_LIM = 4'd3;  // hour units bound once hour tens is 2
  localparam logic [3:0] MAX_HR_T     = 4'd2;

  // Button slots
  localparam int unsigned NUM_BTN   = 5;
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_APPLY = 4;

  function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] hr_tens);
    logic [3:0] mx;
    mx = MAX_SEC_U;
    unique case (pos)
      SEC_U:   mx = MAX_SEC_U;
      SEC_T:   mx = MAX_SEC_T;
      MIN_U:   mx = MAX_MIN_U;
      MIN_T:   mx = MAX_MIN_T;
      HR_U:    mx = (hr_tens == 4'd2) ? MAX_HR_U_LIM : MAX_HR_U;
      HR_T:    mx = MAX_HR_T;
      default: mx = MAX_SEC_U;
    endcase
    return mx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer.
// - Two-flop synchroniser on the raw asynchronous level.
// - On each tick the synchronised level is compared with the accepted (stable) level; a
//   difference seen on DEB_TICKS consecutive ticks updates the stable level.
// - press is a registered one-cycle pulse on each rising edge of the stable level.
// Ports: clk, rst (sync, active-high), tick (sampling strobe), raw (button), press (pulse).
module btn_debounce #(
  parameter int unsigned DEB_TICKS = 20,
  parameter int unsigned CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= stable_d & ~stable_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_setter.sv
// Button-driven editor for a six-digit BCD hh:mm:ss value.
// - Debounces left/right/up/down/apply and turns them into one-cycle presses.
// - On adjust rising, loads cur_time into an edit buffer and moves a cursor over the digits.
// - apply emits a one-cycle PE, qualified as PE_counter (mode 0) or PE_alarm (mode 1).
// Ports:
//   CP, _CR          clock and synchronous active-high clear
//   tick_1KHz        debounce sampling strobe
//   adjust, mode     edit session enable, target select (0 clock, 1 alarm)
//   left..apply      raw buttons
//   cur_time         BCD {hh,mm,ss} loaded at session start
//   pre_hour/min/sec edit buffer
//   index            one-hot cursor, zero outside an edit session
//   PE, PE_counter, PE_alarm  commit strobes
module time_setter
  import clock_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 20,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        CP,
  input  logic        _CR,
  input  logic        tick_1KHz,
  input  logic        adjust,
  input  logic        mode,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        apply,
  input  logic [23:0] cur_time,
  output logic [7:0]  pre_hour,
  output logic [7:0]  pre_min,
  output logic [7:0]  pre_sec,
  output logic [7:0]  index,
  output logic        PE,
  output logic        PE_counter,
  output logic        PE_alarm
);

  // Step one digit up or down, wrapping inside its range. Out-of-range digits resolve to 0 (up)
  // or the maximum (down). Moving hour tens to 2 pulls hour units down to 3 if needed.
  function automatic logic [23:0] step_digit(input logic [23:0] t, input logic [2:0] pos,
                                             input logic inc);
    logic [23:0] r;
    logic [4:0]  lsb;
    logic [3:0]  d, mx, nd;
    r   = t;
    lsb = {pos, 2'b00};
    d   = t[lsb +: 4];
    mx  = digit_max(pos, t[23:20]);
    if (inc) begin
      nd = (d >= mx) ? 4'd0 : d + 4'd1;
    end else begin
      nd = (d == 4'd0 || d > mx) ? mx : d - 4'd1;
    end
    r[lsb +: 4] = nd;
    if (pos == HR_T && nd == 4'd2 && r[19:16] > MAX_HR_U_LIM) begin
      r[19:16] = MAX_HR_U_LIM;
    end
    return r;
  endfunction

  logic [NUM_BTN-1:0] raw_btn, press;

  assign raw_btn[BTN_LEFT]  = left;
  assign raw_btn[BTN_RIGHT] = right;
  assign raw_btn[BTN_UP]    = up;
  assign raw_btn[BTN_DOWN]  = down;
  assign raw_btn[BTN_APPLY] = apply;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_TICKS(DEB_TICKS),
      .CNT_W    (CNT_W)
    ) u_deb (
      .clk  (CP),
      .rst  (_CR),
      .tick (tick_1KHz),
      .raw  (raw_btn[i]),
      .press(press[i])
    );
  end

  ts_state_e   state_q, state_d;
  logic [23:0] buf_q, buf_d;
  logic [2:0]  cur_q, cur_d;
  logic        adjust_q, mode_q;
  logic        pe_q, pe_counter_q, pe_alarm_q;
  logic        pe_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cur_d   = cur_q;
    unique case (state_q)
      StIdle: begin
        if (adjust && !adjust_q) state_d = StLoad;
      end
      StLoad: begin
        if (!adjust) begin
          state_d = StIdle;
        end else begin
          buf_d   = cur_time;
          cur_d   = SEC_U;
          state_d = StEdit;
        end
      end
      StEdit: begin
        if (!adjust) begin
          state_d = StIdle;
        end else if (mode != mode_q) begin
          // Target switched mid-session: reload from the newly selected time.
          state_d = StLoad;
        end else if (press[BTN_APPLY]) begin
          state_d = StCommit;
        end else if (press[BTN_UP]) begin
          buf_d = step_digit(buf_q, cur_q, 1'b1);
        end else if (press[BTN_DOWN]) begin
          buf_d = step_digit(buf_q, cur_q, 1'b0);
        end else if (press[BTN_LEFT]) begin
          cur_d = (cur_q == HR_T) ? SEC_U : cur_q + 3'd1;
        end else if (press[BTN_RIGHT]) begin
          cur_d = (cur_q == SEC_U) ? HR_T : cur_q - 3'd1;
        end
      end
      StCommit: begin
        state_d = adjust ? StEdit : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with the COMMIT cycle.
  assign pe_d = (state_d == StCommit);

  always_ff @(posedge CP) begin
    if (_CR) begin
      state_q      <= StIdle;
      buf_q        <= '0;
      cur_q        <= SEC_U;
      adjust_q     <= 1'b0;
      mode_q       <= 1'b0;
      pe_q         <= 1'b0;
      pe_counter_q <= 1'b0;
      pe_alarm_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cur_q        <= cur_d;
      adjust_q     <= adjust;
      mode_q       <= mode;
      pe_q         <= pe_d;
      pe_counter_q <= pe_d & ~mode;
      pe_alarm_q   <= pe_d & mode;
    end
  end

  always_comb begin
    index = 8'h00;
    if (state_q == StEdit || state_q == StCommit) index[cur_q] = 1'b1;
  end

  assign pre_hour   = buf_q[23:16];
  assign pre_min    = buf_q[15:8];
  assign pre_sec    = buf_q[7:0];
  assign PE         = pe_q;
  assign PE_counter = pe_counter_q;
  assign PE_alarm   = pe_alarm_q;

endmodule

// File: tb/tb_time_setter.sv
module tb_time_setter;

  logic        CP = 1'b0;
  logic        _CR = 1'b1;
  logic        tick_1KHz = 1'b1;
  logic        adjust = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  btn = '0;  // {apply, down, up, right, left}
  logic [23:0] cur_time = '0;
  logic [7:0]  pre_hour, pre_min, pre_sec, index;
  logic        PE, PE_counter, PE_alarm;

  localparam int L = 0, R = 1, U = 2, D = 3, A = 4;

  time_setter #(
    .DEB_TICKS(2),
    .CNT_W    (5)
  ) dut (
    .CP        (CP),
    ._CR       (_CR),
    .tick_1KHz (tick_1KHz),
    .adjust    (adjust),
    .mode      (mode),
    .left      (btn[L]),
    .right     (btn[R]),
    .up        (btn[U]),
    .down      (btn[D]),
    .apply     (btn[A]),
    .cur_time  (cur_time),
    .pre_hour  (pre_hour),
    .pre_min   (pre_min),
    .pre_sec   (pre_sec),
    .index     (index),
    .PE        (PE),
    .PE_counter(PE_counter),
    .PE_alarm  (PE_alarm)
  );

  always #5 CP = ~CP;

  int errors = 0;
  int checks = 0;
  int pe_cnt = 0, pec_cnt = 0, pea_cnt = 0;

  always @(negedge CP) begin
    if (PE) pe_cnt++;
    if (PE_counter) pec_cnt++;
    if (PE_alarm) pea_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic press_btn(input int idx);
    btn[idx] = 1'b1;
    cycles(8);
    btn[idx] = 1'b0;
    cycles(8);
  endtask

  initial begin
    int pe0, pec0, pea0;
    bit found;

    // Reset then idle
    cycles(2);
    _CR = 1'b0;
    cycles(1);
    check("rst_hour", pre_hour, 8'h00);
    check("rst_min", pre_min, 8'h00);
    check("rst_sec", pre_sec, 8'h00);
    check("rst_index", index, 8'h00);
    cycles(100);
    check("idle_no_pe", pe_cnt, 0);

    // Session load and commit to counter
    cur_time = 24'h235958;
    adjust   = 1'b1;
    cycles(4);
    check("load_index", index, 8'h01);
    check("load_hour", pre_hour, 8'h23);
    check("load_min", pre_min, 8'h59);
    check("load_sec", pre_sec, 8'h58);
    press_btn(A);
    check("commit_pe", pe_cnt, 1);
    check("commit_pe_counter", pec_cnt, 1);
    check("commit_pe_alarm", pea_cnt, 0);
    check("commit_buf", pre_sec, 8'h58);

    // Wrap edits
    press_btn(U);
    check("sec_up1", pre_sec, 8'h59);
    press_btn(U);
    check("sec_up_wrap", pre_sec, 8'h50);
    for (int i = 0; i < 5; i++) press_btn(L);
    check("left5", index, 8'h20);
    press_btn(L);
    check("left_wrap", index, 8'h01);
    press_btn(R);
    check("right_wrap", index, 8'h20);

    // Hour clamp: 23 -> 13 -> (units down x4) 19 -> tens up 23 -> 03 -> 23
    press_btn(D);
    check("hr_tens_down", pre_hour, 8'h13);
    press_btn(R);
    check("cursor_hr_u", index, 8'h10);
    for (int i = 0; i < 4; i++) press_btn(D);
    check("hr_units_wrap", pre_hour, 8'h19);
    press_btn(L);
    press_btn(U);
    check("hr_clamp", pre_hour, 8'h23);
    press_btn(U);
    check("hr_tens_wrap", pre_hour, 8'h03);
    press_btn(D);
    check("hr_tens_down_wrap", pre_hour, 8'h23);

    // 1-tick glitch
    btn[U] = 1'b1;
    cycles(1);
    btn[U] = 1'b0;
    cycles(10);
    check("glitch", pre_hour, 8'h23);

    // Bounce 1,0,1,1 then held: single increment
    btn[U] = 1'b1; cycles(1);
    btn[U] = 1'b0; cycles(1);
    btn[U] = 1'b1; cycles(10);
    btn[U] = 1'b0; cycles(10);
    check("bounce_once", pre_hour, 8'h03);

    // apply and up together: commit only
    pe0 = pe_cnt;
    btn[A] = 1'b1;
    btn[U] = 1'b1;
    cycles(8);
    btn = '0;
    cycles(8);
    check("prio_pe", pe_cnt - pe0, 1);
    check("prio_digit", pre_hour, 8'h03);

    // Abort
    pe0 = pe_cnt;
    adjust = 1'b0;
    cycles(3);
    check("abort_index", index, 8'h00);
    check("abort_keep", pre_hour, 8'h03);
    press_btn(A);
    check("abort_no_pe", pe_cnt - pe0, 0);

    // Mode switch reload, then commit to alarm
    cur_time = 24'h235958;
    adjust   = 1'b1;
    cycles(4);
    press_btn(L);
    cur_time = 24'h070000;
    mode     = 1'b1;
    cycles(4);
    check("reload_hour", pre_hour, 8'h07);
    check("reload_min", pre_min, 8'h00);
    check("reload_sec", pre_sec, 8'h00);
    check("reload_index", index, 8'h01);
    pec0 = pec_cnt;
    pea0 = pea_cnt;
    press_btn(A);
    check("alarm_pe", pea_cnt - pea0, 1);
    check("alarm_no_counter", pec_cnt - pec0, 0);

    // Reset while in COMMIT
    found = 1'b0;
    btn[A] = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CP);
      if (PE) found = 1'b1;
    end
    check("commit_seen", found, 1);
    _CR    = 1'b1;
    adjust = 1'b0;
    btn    = '0;
    cycles(1);
    check("cr_commit_pe", PE, 0);
    check("cr_commit_alarm", PE_alarm, 0);
    check("cr_commit_index", index, 8'h00);
    check("cr_commit_hour", pre_hour, 8'h00);
    _CR = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
